stage3_execute: RTL and testbench
=================================

Name: stage3_execute

Overview:
- Execute stage of the 5-stage RISC-V pipeline.
- Takes decoded operands and control from the ID/EX register, applies forwarding selects, and computes the ALU result; MUL runs on a 32-cycle shift-add engine.
- Holds the EX/MEM pipeline register whose outputs drive the memory stage directly: control bits, ALU result/bypass, store data and destination address.

Parameters:
N, 32, datapath width; shift amount uses the low 5 bits; MUL iteration count equals N.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en_ExMem  in  1  EX/MEM register and MUL FSM advance enable; low = hold everything
flush  in  1  synchronous bubble insert; kills any MUL in progress
IdEx_Regwrite  in  1  register-file write request
IdEx_MemtoReg  in  1  writeback selects memory data
IdEx_MemRead  in  1  load
IdEx_MemWrite  in  1  store
IdEx_AluSrc  in  1  operand B select: 1 = IdEx_Imm, 0 = forwarded rs2
IdEx_AluOp  in  4  operation code, listed in Behaviour
IdEx_Rs1Data  in  N  rs1 register-file value
IdEx_Rs2Data  in  N  rs2 register-file value
IdEx_Imm  in  N  sign-extended immediate
IdEx_RdAdd  in  5  destination register
Fwd_A  in  2  rs1 source: 00 regfile, 01 MemWb_WbData, 10 ExMem_AluResBypass, 11 same as 00
Fwd_B  in  2  rs2 source, same encoding as Fwd_A
MemWb_WbData  in  N  writeback-stage result
ex_busy  out  1  combinational; MUL in progress, upstream must stall
ExMem_Regwrite  out  1  registered control
ExMem_MemtoReg  out  1  registered control
ExMem_MemRead  out  1  registered control
ExMem_MemWrite  out  1  registered control
ExMem_AluResBypass  out  N  registered ALU result / memory address
ExMem_WriteData  out  N  registered store data (forwarded rs2)
ExMem_RdAdd  out  5  registered destination address

Behaviour:
- Reset: every output and internal register goes to 0 and the FSM goes to IDLE, asynchronously, with no clock edge required.
- Operand selection:
  - opA = Fwd_A-selected value.
  - fwdB = Fwd_B-selected value.
  - opB = IdEx_AluSrc ? IdEx_Imm : fwdB.
  - Store data is always fwdB.
- AluOp encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA (shift amount = opB[4:0])
  - 1000 SLT (signed), 1001 SLTU (unsigned), 1010 MUL (low N bits of the product), 1011 PASSB
  - 1100-1111: result 0
- Add and subtract wrap modulo 2^N. SLT and SLTU return 0 or 1 zero-extended.
- Non-MUL latency: 1 cycle. Inputs in cycle T appear on the ExMem_* outputs after the rising edge ending cycle T.
- FSM states are IDLE, MUL and DONE. All transitions require en_ExMem=1 and flush=0.
- IDLE with AluOp=MUL:
  - ex_busy=1.
  - At the edge: latch opA as the multiplicand and opB as the multiplier, clear the accumulator, set the counter to 0, go to MUL.
  - The EX/MEM register loads a bubble: the four control bits = 0, data fields = 0.
- MUL state:
  - ex_busy=1.
  - Each edge: if multiplier[0], acc += mcand; mcand <<= 1; multiplier >>= 1; cnt++.
  - After the N-th iteration (cnt = N-1 at the edge), go to DONE.
  - The EX/MEM register loads bubbles throughout.
- DONE state:
  - ex_busy=0 and the ALU result = acc.
  - The EX/MEM register loads normally using the IdEx_* controls, which are still held by the stall.
  - Go to IDLE.
- MUL timing (N=32): ex_busy is high for 33 consecutive cycles; the result is on ExMem_* 34 cycles after the MUL is first presented.
- Operands are latched in the first cycle only. Forwarded values changing during the stall have no effect.
- en_ExMem=0: all registers and FSM state hold. ex_busy still reflects the current state.
- flush=1 (priority over en_ExMem): at the edge, the four control outputs = 0, data outputs = 0, FSM goes to IDLE, and any in-progress MUL is discarded.
- ex_busy goes low combinationally in the cycle flush is asserted.
- A bubble never asserts Regwrite, MemRead or MemWrite.

Test Plan:
- ADD: Rs1Data=5, Rs2Data=7, Fwd 00/00, AluSrc=0, Regwrite=1, RdAdd=3 -> next edge ExMem_AluResBypass=12, ExMem_RdAdd=3, ExMem_Regwrite=1, ex_busy=0 throughout.
- Forwarding: follow the ADD with Fwd_A=10, AluSrc=1, Imm=0xFFFFFFFE, MemWrite=1, Fwd_B=01, MemWb_WbData=0xDEADBEEF -> ExMem_AluResBypass=10, ExMem_WriteData=0xDEADBEEF, ExMem_MemWrite=1.
- ALU corners:
  - SRA 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000.
  - SLT -1 vs 1 -> 1; SLTU -> 0.
  - ADD 0xFFFFFFFF+1 -> 0.
  - AluOp 1111 -> 0.
- MUL 0xFFFFFFFF x 3, inputs held -> ex_busy high exactly 33 cycles; ExMem_Regwrite/MemRead/MemWrite=0 during busy; ExMem_AluResBypass=0xFFFFFFFD 34 cycles after the start; a second MUL 0x10000 x 0x10000 -> 0.
- Flush at cycle 10 of a MUL -> ex_busy drops the same cycle, outputs zeroed at the edge; a following ADD 2+2 completes with 1-cycle latency (result 4).
- Hold and reset:
  - en_ExMem=0 for 3 cycles mid-MUL -> counter and outputs frozen; total busy count becomes 36.
  - rst_n pulsed low between edges mid-MUL -> all outputs 0 and ex_busy=0 immediately, before the next edge.

Source files
------------

// File: rtl/stage3_execute.sv
// Execute stage: forwarding muxes, single-cycle ALU, 32-cycle shift-add MUL FSM
// and the EX/MEM pipeline register feeding the memory stage.
module stage3_execute #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_ExMem,
  input  logic         flush,
  input  logic         IdEx_Regwrite,
  input  logic         IdEx_MemtoReg,
  input  logic         IdEx_MemRead,
  input  logic         IdEx_MemWrite,
  input  logic         IdEx_AluSrc,
  input  logic [3:0]   IdEx_AluOp,
  input  logic [N-1:0] IdEx_Rs1Data,
  input  logic [N-1:0] IdEx_Rs2Data,
  input  logic [N-1:0] IdEx_Imm,
  input  logic [4:0]   IdEx_RdAdd,
  input  logic [1:0]   Fwd_A,
  input  logic [1:0]   Fwd_B,
  input  logic [N-1:0] MemWb_WbData,
  output logic         ex_busy,
  output logic         ExMem_Regwrite,
  output logic         ExMem_MemtoReg,
  output logic         ExMem_MemRead,
  output logic         ExMem_MemWrite,
  output logic [N-1:0] ExMem_AluResBypass,
  output logic [N-1:0] ExMem_WriteData,
  output logic [4:0]   ExMem_RdAdd
);

  localparam int unsigned CntW = $clog2(N);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] OpMul = 4'b1010;

  logic [1:0]      stateQ, stateD;
  logic [N-1:0]    mcandQ, mcandD;
  logic [N-1:0]    mplierQ, mplierD;
  logic [N-1:0]    accQ, accD;
  logic [CntW-1:0] cntQ, cntD;

  logic [N-1:0] opA, fwdB, opB, aluRes;
  logic [4:0]   shamt;
  logic         isMul, bubble;

  always_comb begin
    unique case (Fwd_A)
      2'b01:   opA = MemWb_WbData;
      2'b10:   opA = ExMem_AluResBypass;
      default: opA = IdEx_Rs1Data;
    endcase
    unique case (Fwd_B)
      2'b01:   fwdB = MemWb_WbData;
      2'b10:   fwdB = ExMem_AluResBypass;
      default: fwdB = IdEx_Rs2Data;
    endcase
    opB   = IdEx_AluSrc ? IdEx_Imm : fwdB;
    shamt = opB[4:0];
  end

  always_comb begin
    aluRes = '0;
    case (IdEx_AluOp)
      4'b0000: aluRes = opA + opB;
      4'b0001: aluRes = opA - opB;
      4'b0010: aluRes = opA & opB;
      4'b0011: aluRes = opA | opB;
      4'b0100: aluRes = opA ^ opB;
      4'b0101: aluRes = opA << shamt;
      4'b0110: aluRes = opA >> shamt;
      4'b0111: aluRes = $unsigned($signed(opA) >>> shamt);
      4'b1000: aluRes = {{(N-1){1'b0}}, $signed(opA) < $signed(opB)};
      4'b1001: aluRes = {{(N-1){1'b0}}, opA < opB};
      4'b1010: aluRes = accQ;  // only consumed in StDone; otherwise bubbled
      4'b1011: aluRes = opB;
      default: aluRes = '0;
    endcase
  end

  assign isMul  = (IdEx_AluOp == OpMul);
  assign bubble = (stateQ == StMul) || (stateQ == StIdle && isMul);
  // Gated by reset so a held MUL opcode cannot raise busy while the stage is in reset.
  assign ex_busy = rst_n && !flush && bubble;

  always_comb begin
    stateD  = stateQ;
    mcandD  = mcandQ;
    mplierD = mplierQ;
    accD    = accQ;
    cntD    = cntQ;
    case (stateQ)
      StIdle: begin
        if (isMul) begin
          stateD  = StMul;
          mcandD  = opA;
          mplierD = opB;
          accD    = '0;
          cntD    = '0;
        end
      end
      StMul: begin
        if (mplierQ[0]) accD = accQ + mcandQ;
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        cntD    = cntQ + 1'b1;
        if (cntQ == CntW'(N - 1)) stateD = StDone;
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ             <= StIdle;
      mcandQ             <= '0;
      mplierQ            <= '0;
      accQ               <= '0;
      cntQ               <= '0;
      ExMem_Regwrite     <= 1'b0;
      ExMem_MemtoReg     <= 1'b0;
      ExMem_MemRead      <= 1'b0;
      ExMem_MemWrite     <= 1'b0;
      ExMem_AluResBypass <= '0;
      ExMem_WriteData    <= '0;
      ExMem_RdAdd        <= '0;
    end else if (flush) begin
      stateQ             <= StIdle;
      ExMem_Regwrite     <= 1'b0;
      ExMem_MemtoReg     <= 1'b0;
      ExMem_MemRead      <= 1'b0;
      ExMem_MemWrite     <= 1'b0;
      ExMem_AluResBypass <= '0;
      ExMem_WriteData    <= '0;
      ExMem_RdAdd        <= '0;
    end else if (en_ExMem) begin
      stateQ  <= stateD;
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      accQ    <= accD;
      cntQ    <= cntD;
      if (bubble) begin
        ExMem_Regwrite     <= 1'b0;
        ExMem_MemtoReg     <= 1'b0;
        ExMem_MemRead      <= 1'b0;
        ExMem_MemWrite     <= 1'b0;
        ExMem_AluResBypass <= '0;
        ExMem_WriteData    <= '0;
        ExMem_RdAdd        <= '0;
      end else begin
        ExMem_Regwrite     <= IdEx_Regwrite;
        ExMem_MemtoReg     <= IdEx_MemtoReg;
        ExMem_MemRead      <= IdEx_MemRead;
        ExMem_MemWrite     <= IdEx_MemWrite;
        ExMem_AluResBypass <= aluRes;
        ExMem_WriteData    <= fwdB;
        ExMem_RdAdd        <= IdEx_RdAdd;
      end
    end
  end

endmodule

// File: tb/tb_stage3_execute.sv
// Directed bench for stage3_execute: ALU ops, forwarding, MUL timing, flush, hold and reset.
module tb_stage3_execute;

  logic        clk, rst_n, en_ExMem, flush;
  logic        IdEx_Regwrite, IdEx_MemtoReg, IdEx_MemRead, IdEx_MemWrite, IdEx_AluSrc;
  logic [3:0]  IdEx_AluOp;
  logic [31:0] IdEx_Rs1Data, IdEx_Rs2Data, IdEx_Imm, MemWb_WbData;
  logic [4:0]  IdEx_RdAdd;
  logic [1:0]  Fwd_A, Fwd_B;
  logic        ex_busy, ExMem_Regwrite, ExMem_MemtoReg, ExMem_MemRead, ExMem_MemWrite;
  logic [31:0] ExMem_AluResBypass, ExMem_WriteData;
  logic [4:0]  ExMem_RdAdd;

  int total = 0;
  int passed = 0;
  int failed = 0;

  stage3_execute #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_ExMem(en_ExMem), .flush(flush),
    .IdEx_Regwrite(IdEx_Regwrite), .IdEx_MemtoReg(IdEx_MemtoReg),
    .IdEx_MemRead(IdEx_MemRead), .IdEx_MemWrite(IdEx_MemWrite),
    .IdEx_AluSrc(IdEx_AluSrc), .IdEx_AluOp(IdEx_AluOp),
    .IdEx_Rs1Data(IdEx_Rs1Data), .IdEx_Rs2Data(IdEx_Rs2Data), .IdEx_Imm(IdEx_Imm),
    .IdEx_RdAdd(IdEx_RdAdd), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .MemWb_WbData(MemWb_WbData),
    .ex_busy(ex_busy), .ExMem_Regwrite(ExMem_Regwrite), .ExMem_MemtoReg(ExMem_MemtoReg),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemWrite(ExMem_MemWrite),
    .ExMem_AluResBypass(ExMem_AluResBypass), .ExMem_WriteData(ExMem_WriteData),
    .ExMem_RdAdd(ExMem_RdAdd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    IdEx_AluOp    = op;
    IdEx_Rs1Data  = a;
    IdEx_Rs2Data  = b;
    IdEx_Imm      = 32'h0;
    IdEx_AluSrc   = 1'b0;
    Fwd_A         = 2'b00;
    Fwd_B         = 2'b00;
    IdEx_Regwrite = 1'b1;
    IdEx_MemtoReg = 1'b0;
    IdEx_MemRead  = 1'b0;
    IdEx_MemWrite = 1'b0;
    IdEx_RdAdd    = 5'd3;
  endtask

  // MUL already presented; runs until the result has been registered.
  task automatic runMul(input string tag, input logic [31:0] expRes,
                        input int holdAt, input int holdLen);
    int busyCnt = 0;
    int lat = 34 + holdLen;
    logic bad = 1'b0;
    for (int i = 0; i < lat; i++) begin
      en_ExMem = !(i >= holdAt && i < holdAt + holdLen);
      if (i == 5) IdEx_Rs1Data = 32'h1234_5678;
      #1;
      if (ex_busy) busyCnt++;
      if (i > 0 && (ExMem_Regwrite || ExMem_MemRead || ExMem_MemWrite ||
                    ExMem_AluResBypass != 32'h0)) bad = 1'b1;
      tick();
    end
    en_ExMem = 1'b1;
    check({tag, "_busy"}, 32'(busyCnt), 32'(33 + holdLen));
    check({tag, "_bubble"}, {31'b0, bad}, 32'h0);
    check({tag, "_res"}, ExMem_AluResBypass, expRes);
    check({tag, "_rw"}, {31'b0, ExMem_Regwrite}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b1; en_ExMem = 1'b1; flush = 1'b0; MemWb_WbData = 32'h0;
    drv(4'b0000, 32'h0, 32'h0);
    IdEx_Regwrite = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, ex_busy}, 32'h0);
    check("rst_rw", {31'b0, ExMem_Regwrite}, 32'h0);
    check("rst_res", ExMem_AluResBypass, 32'h0);
    check("rst_wd", ExMem_WriteData, 32'h0);
    check("rst_rd", {27'b0, ExMem_RdAdd}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD 5+7
    drv(4'b0000, 32'd5, 32'd7);
    #1 check("add_busy", {31'b0, ex_busy}, 32'h0);
    tick();
    check("add_res", ExMem_AluResBypass, 32'd12);
    check("add_rd", {27'b0, ExMem_RdAdd}, 32'd3);
    check("add_rw", {31'b0, ExMem_Regwrite}, 32'h1);

    // Forward bypass (12) + imm -2; store data from writeback
    drv(4'b0000, 32'h0, 32'h0);
    Fwd_A = 2'b10; Fwd_B = 2'b01; IdEx_AluSrc = 1'b1; IdEx_Imm = 32'hFFFF_FFFE;
    IdEx_MemWrite = 1'b1; IdEx_Regwrite = 1'b0; MemWb_WbData = 32'hDEAD_BEEF;
    tick();
    check("fwd_res", ExMem_AluResBypass, 32'd10);
    check("fwd_wd", ExMem_WriteData, 32'hDEAD_BEEF);
    check("fwd_mw", {31'b0, ExMem_MemWrite}, 32'h1);
    check("fwd_rw", {31'b0, ExMem_Regwrite}, 32'h0);

    // ALU corners
    drv(4'b0111, 32'h8000_0000, 32'h0);
    IdEx_AluSrc = 1'b1; IdEx_Imm = 32'd4;
    tick();
    check("sra", ExMem_AluResBypass, 32'hF800_0000);
    drv(4'b0110, 32'h8000_0000, 32'd4);
    IdEx_MemRead = 1'b1; IdEx_MemtoReg = 1'b1;
    tick();
    check("srl", ExMem_AluResBypass, 32'h0800_0000);
    check("srl_mr", {30'b0, ExMem_MemRead, ExMem_MemtoReg}, 32'h3);
    drv(4'b1000, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt", ExMem_AluResBypass, 32'd1);
    drv(4'b1001, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("sltu", ExMem_AluResBypass, 32'd0);
    drv(4'b0000, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("add_wrap", ExMem_AluResBypass, 32'd0);
    drv(4'b0001, 32'd5, 32'd7);
    tick();
    check("sub", ExMem_AluResBypass, 32'hFFFF_FFFE);
    drv(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick();
    check("xor", ExMem_AluResBypass, 32'h0FF0_0FF0);
    drv(4'b1111, 32'd5, 32'd7);
    tick();
    check("op1111", ExMem_AluResBypass, 32'd0);

    // Back-to-back MULs, then one with a 3-cycle hold
    drv(4'b1010, 32'hFFFF_FFFF, 32'd3);
    runMul("mul1", 32'hFFFF_FFFD, 100, 0);
    IdEx_Rs1Data = 32'h0001_0000; IdEx_Rs2Data = 32'h0001_0000;
    runMul("mul2", 32'h0, 100, 0);
    drv(4'b1010, 32'd7, 32'd6);
    runMul("mulhold", 32'd42, 10, 3);

    // Flush at cycle 10 of a MUL
    drv(4'b1010, 32'd5, 32'd5);
    repeat (10) tick();
    flush = 1'b1;
    #1 check("fl_busy", {31'b0, ex_busy}, 32'h0);
    tick();
    flush = 1'b0;
    check("fl_rw", {31'b0, ExMem_Regwrite}, 32'h0);
    check("fl_res", ExMem_AluResBypass, 32'h0);
    drv(4'b0000, 32'd2, 32'd2);
    #1 check("fl_add_busy", {31'b0, ex_busy}, 32'h0);
    tick();
    check("fl_add_res", ExMem_AluResBypass, 32'd4);
    check("fl_add_rw", {31'b0, ExMem_Regwrite}, 32'h1);

    // Asynchronous reset mid-MUL, then with live outputs
    drv(4'b1010, 32'd9, 32'd9);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("amul_busy", {31'b0, ex_busy}, 32'h0);
    check("amul_res", ExMem_AluResBypass, 32'h0);
    check("amul_rw", {31'b0, ExMem_Regwrite}, 32'h0);
    #1 rst_n = 1'b1;
    drv(4'b0000, 32'd1, 32'd1);
    #1 check("post_rst_busy", {31'b0, ex_busy}, 32'h0);
    tick();
    check("post_rst_add", ExMem_AluResBypass, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_res", ExMem_AluResBypass, 32'h0);
    check("arst_rw", {31'b0, ExMem_Regwrite}, 32'h0);
    check("arst_rd", {27'b0, ExMem_RdAdd}, 32'h0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
